jpeg_scan_ctrl: RTL

// Sequences the entropy-coded byte stream into jpeg_bitbuffer for one scan. Removes 0xFF00

---
 rtl/jpeg_pkg.sv | 24 ++
 rtl/jpeg_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and marker constants for the JPEG scan controller.
package jpeg_pkg;

  // Scan sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    FF_SEEN  = 3'd2,
    RST_WAIT = 3'd3,
    FLUSH    = 3'd4,
    DONE     = 3'd5
  } scan_state_t;

  localparam logic [7:0] MRK_PREFIX = 8'hFF;
  localparam logic [7:0] MRK_STUFF  = 8'h00;
  localparam logic [7:0] MRK_RST0   = 8'hD0;
  localparam logic [7:0] MRK_EOI    = 8'hD9;

  // True for RST0..RST7 (D0..D7): upper five bits match RST0
  function automatic logic is_rst_marker(input logic [7:0] b);
    return (b[7:3] == MRK_RST0[7:3]);
  endfunction

endpackage

// File: rtl/jpeg_scan_ctrl.sv
// Feeds one scan's entropy-coded bytes into jpeg_bitbuffer: strips FF00 stuffing,
// drops FF fill bytes, drains/flushes on RSTn markers and terminates on EOI.
module jpeg_scan_ctrl
  import jpeg_pkg::*;
#(
  parameter int RST_CHECK = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       img_start_i,
  input  logic       scan_start_i,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  input  logic       inport_last_i,
  output logic       inport_accept_o,
  output logic       bb_valid_o,
  output logic [7:0] bb_data_o,
  input  logic       bb_accept_i,
  output logic       bb_last_o,
  output logic       bb_flush_o,
  input  logic       dec_idle_i,
  output logic       restart_o,
  output logic       eoi_o,
  output logic       rst_err_o,
  output logic       marker_err_o
);

  scan_state_t state_r, state_s;
  logic [2:0]  exp_idx_r, exp_idx_s;
  logic [2:0]  rst_idx_r, rst_idx_s;
  logic        flush_r, flush_s;
  logic        last_r, last_s;
  logic        eoi_r, eoi_s;
  logic        restart_r, restart_s;
  logic        rst_err_r, rst_err_set_s;
  logic        mrk_err_r, mrk_err_set_s;
  logic        accept_s, bb_valid_s, end_s;
  logic [7:0]  bb_data_s;
  logic        is_prefix_s, is_stuff_s, is_rst_s, is_eoi_s;

  // Classify the byte currently offered by the source
  always_comb begin
    is_prefix_s = (inport_data_i == MRK_PREFIX);
    is_stuff_s  = (inport_data_i == MRK_STUFF);
    is_rst_s    = is_rst_marker(inport_data_i);
    is_eoi_s    = (inport_data_i == MRK_EOI);
  end

  // Next-state, handshake and pulse-request logic
  always_comb begin
    state_s       = state_r;
    exp_idx_s     = exp_idx_r;
    rst_idx_s     = rst_idx_r;
    accept_s      = 1'b0;
    bb_valid_s    = 1'b0;
    bb_data_s     = 8'h00;
    flush_s       = 1'b0;
    last_s        = 1'b0;
    eoi_s         = 1'b0;
    restart_s     = 1'b0;
    rst_err_set_s = 1'b0;
    mrk_err_set_s = 1'b0;
    end_s         = 1'b0;
    if (img_start_i) begin
      // Abort wins over everything: no handshake, no pulses
      state_s   = IDLE;
      exp_idx_s = 3'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (scan_start_i) begin
            state_s   = DATA;
            flush_s   = 1'b1;
            exp_idx_s = 3'd0;
          end else begin
            state_s = state_r;
          end
        end
        DATA: begin
          if (!inport_valid_i) begin
            state_s = state_r;
          end else if (is_prefix_s) begin
            accept_s      = 1'b1;
            state_s       = FF_SEEN;
            end_s         = inport_last_i;
            mrk_err_set_s = inport_last_i;
          end else begin
            bb_valid_s    = 1'b1;
            bb_data_s     = inport_data_i;
            accept_s      = bb_accept_i;
            end_s         = bb_accept_i & inport_last_i;
            mrk_err_set_s = bb_accept_i & inport_last_i;
          end
        end
        FF_SEEN: begin
          if (!inport_valid_i) begin
            state_s = state_r;
          end else if (is_stuff_s) begin
            // Stuffed FF00 becomes a literal FF data byte
            bb_valid_s    = 1'b1;
            bb_data_s     = MRK_PREFIX;
            accept_s      = bb_accept_i;
            state_s       = bb_accept_i ? DATA : FF_SEEN;
            end_s         = bb_accept_i & inport_last_i;
            mrk_err_set_s = bb_accept_i & inport_last_i;
          end else if (is_prefix_s) begin
            // Fill byte: swallow, marker prefix still pending
            accept_s      = 1'b1;
            end_s         = inport_last_i;
            mrk_err_set_s = inport_last_i;
          end else if (is_rst_s) begin
            accept_s      = 1'b1;
            rst_idx_s     = inport_data_i[2:0];
            rst_err_set_s = (RST_CHECK != 0) && (inport_data_i[2:0] != exp_idx_r);
            if (inport_last_i) begin
              end_s         = 1'b1;
              mrk_err_set_s = 1'b1;
            end else begin
              last_s  = 1'b1;
              state_s = RST_WAIT;
            end
          end else begin
            // EOI, or any unexpected marker treated as end of scan
            accept_s      = 1'b1;
            end_s         = 1'b1;
            mrk_err_set_s = ~is_eoi_s;
          end
        end
        RST_WAIT: begin
          if (dec_idle_i) begin
            state_s   = FLUSH;
            flush_s   = 1'b1;
            restart_s = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        FLUSH: begin
          exp_idx_s = rst_idx_r + 3'd1;
          state_s   = DATA;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
      if (end_s) begin
        state_s = DONE;
        last_s  = 1'b1;
        eoi_s   = 1'b1;
      end else begin
        eoi_s = 1'b0;
      end
    end
  end

  // State, marker index tracking, registered pulses and sticky error flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= IDLE;
      exp_idx_r <= 3'd0;
      rst_idx_r <= 3'd0;
      flush_r   <= 1'b0;
      last_r    <= 1'b0;
      eoi_r     <= 1'b0;
      restart_r <= 1'b0;
      rst_err_r <= 1'b0;
      mrk_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      exp_idx_r <= exp_idx_s;
      rst_idx_r <= rst_idx_s;
      flush_r   <= flush_s;
      last_r    <= last_s;
      eoi_r     <= eoi_s;
      restart_r <= restart_s;
      if (img_start_i) begin
        rst_err_r <= 1'b0;
        mrk_err_r <= 1'b0;
      end else begin
        rst_err_r <= rst_err_r | rst_err_set_s;
        mrk_err_r <= mrk_err_r | mrk_err_set_s;
      end
    end
  end

  assign inport_accept_o = accept_s;
  assign bb_valid_o      = bb_valid_s;
  assign bb_data_o       = bb_data_s;
  assign bb_flush_o      = flush_r;
  assign bb_last_o       = last_r;
  assign eoi_o           = eoi_r;
  assign restart_o       = restart_r;
  assign rst_err_o       = rst_err_r;
  assign marker_err_o    = mrk_err_r;

endmodule
